// File: rtl/uart_alu_pkt_parser.sv
// ---------------------------------------------------------------------------
// uart_alu_pkt_parser
//
// Packet deframer between the UART receive byte stream and the ALU datapath.
// Host packet: opcode, reserved, length LSB, length MSB, payload. The length
// is the total byte count including the 4-byte header. Payload bytes are
// regrouped into 32-bit little-endian words (first byte in [7:0]) and emitted
// with the opcode on tuser. Unknown opcodes and bad lengths are dropped and
// reported with a one-cycle err_o pulse.
//
// Optional feature macro: PARSER_TIMEOUT_EN
//   When defined, an idle counter aborts a stalled packet after
//   TIMEOUT_CYCLES cycles without an accepted byte.
//
// Handshake rule (both streams): a beat transfers on a rising clk_i edge
// where tvalid && tready; a master holds its data stable while tvalid=1 and
// tready=0.
//
// Ports:
//   clk_i, reset_i       clock, synchronous active-high reset
//   s_axis_tdata/tvalid  received byte stream in
//   s_axis_tready        parser can take the byte
//   m_axis_tdata         payload word
//   m_axis_tkeep         valid byte lanes
//   m_axis_tuser         opcode of the packet owning the word
//   m_axis_tlast         final word of packet
//   m_axis_tvalid/tready word stream out
//   err_o                one-cycle framing error pulse
//   dbg_state_o          current FSM state (debug visibility)
// ---------------------------------------------------------------------------
module uart_alu_pkt_parser #(
   parameter logic [7:0]  OP_ADD         = 8'h01,
   parameter logic [7:0]  OP_MUL         = 8'h02,
   parameter logic [7:0]  OP_ECHO        = 8'hEC
`ifdef PARSER_TIMEOUT_EN
   , parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
`endif
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   output logic [31:0] m_axis_tdata,
   output logic [3:0]  m_axis_tkeep,
   output logic [7:0]  m_axis_tuser,
   output logic        m_axis_tlast,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        err_o,
   output logic [2:0]  dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RSVD    = 3'd1,
      S_LEN_LO  = 3'd2,
      S_LEN_HI  = 3'd3,
      S_PAYLOAD = 3'd4,
      S_DISCARD = 3'd5
   } state_t;

   state_t      r_state;
   logic [7:0]  r_opcode;
   logic [7:0]  r_len_lo;
   logic [15:0] r_remaining;
   logic [1:0]  r_byte_idx;
   logic [23:0] r_word_buf;
   logic [31:0] r_tdata;
   logic [3:0]  r_tkeep;
   logic [7:0]  r_tuser;
   logic        r_tlast;
   logic        r_tvalid;
   logic        r_err;
`ifdef PARSER_TIMEOUT_EN
   logic [31:0] r_idle_cnt;
`endif

   logic        w_byte_acc;
   logic        w_word_done;
   logic        w_drain;
   logic [15:0] w_len;
   logic [15:0] w_pay_len;
   logic        w_op_known;
   logic        w_op_words;
   logic [31:0] w_word;
   logic [3:0]  w_keep;

   // The byte being accepted in PAYLOAD closes a word on lane 3 or on the
   // final payload byte.
   assign w_word_done = (r_byte_idx == 2'd3) || (r_remaining == 16'd1);
   assign w_drain     = r_tvalid && m_axis_tready;
   // Only stall when a completed word would have nowhere to go.
   assign s_axis_tready = !((r_state == S_PAYLOAD) && w_word_done &&
                            r_tvalid && !m_axis_tready);
   assign w_byte_acc  = s_axis_tvalid && s_axis_tready;

   assign w_len      = {s_axis_tdata, r_len_lo};
   assign w_pay_len  = w_len - 16'd4;
   assign w_op_words = (r_opcode == OP_ADD) || (r_opcode == OP_MUL);
   assign w_op_known = w_op_words || (r_opcode == OP_ECHO);

   // Merge the incoming byte with the buffered lanes; lanes above it are zero.
   always_comb begin
      w_word = 32'd0;
      w_keep = 4'b0000;
      case (r_byte_idx)
         2'd0: begin w_word = {24'd0, s_axis_tdata};                   w_keep = 4'b0001; end
         2'd1: begin w_word = {16'd0, s_axis_tdata, r_word_buf[7:0]};  w_keep = 4'b0011; end
         2'd2: begin w_word = {8'd0, s_axis_tdata, r_word_buf[15:0]};  w_keep = 4'b0111; end
         default: begin w_word = {s_axis_tdata, r_word_buf};           w_keep = 4'b1111; end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state     <= S_IDLE;
         r_opcode    <= 8'd0;
         r_len_lo    <= 8'd0;
         r_remaining <= 16'd0;
         r_byte_idx  <= 2'd0;
         r_word_buf  <= 24'd0;
         r_tdata     <= 32'd0;
         r_tkeep     <= 4'd0;
         r_tuser     <= 8'd0;
         r_tlast     <= 1'b0;
         r_tvalid    <= 1'b0;
         r_err       <= 1'b0;
`ifdef PARSER_TIMEOUT_EN
         r_idle_cnt  <= 32'd0;
`endif
      end else begin
         r_err <= 1'b0;
         // A load below overrides this clear, giving zero-bubble refill.
         if (w_drain) r_tvalid <= 1'b0;

         case (r_state)
            S_IDLE: if (w_byte_acc) begin
               r_opcode <= s_axis_tdata;
               r_state  <= S_RSVD;
            end
            S_RSVD: if (w_byte_acc) r_state <= S_LEN_LO;
            S_LEN_LO: if (w_byte_acc) begin
               r_len_lo <= s_axis_tdata;
               r_state  <= S_LEN_HI;
            end
            S_LEN_HI: if (w_byte_acc) begin
               r_remaining <= w_pay_len;
               r_byte_idx  <= 2'd0;
               if (w_len < 16'd5) begin
                  r_err   <= 1'b1;
                  r_state <= S_IDLE;
               end else if (!w_op_known ||
                            (w_op_words && (w_pay_len[1:0] != 2'd0))) begin
                  r_err   <= 1'b1;
                  r_state <= S_DISCARD;
               end else begin
                  r_state <= S_PAYLOAD;
               end
            end
            S_PAYLOAD: if (w_byte_acc) begin
               r_remaining <= r_remaining - 16'd1;
               r_byte_idx  <= r_byte_idx + 2'd1;
               case (r_byte_idx)
                  2'd0:    r_word_buf[7:0]   <= s_axis_tdata;
                  2'd1:    r_word_buf[15:8]  <= s_axis_tdata;
                  2'd2:    r_word_buf[23:16] <= s_axis_tdata;
                  default: ;
               endcase
               if (w_word_done) begin
                  r_tvalid   <= 1'b1;
                  r_tdata    <= w_word;
                  r_tkeep    <= w_keep;
                  r_tuser    <= r_opcode;
                  r_tlast    <= (r_remaining == 16'd1);
                  r_byte_idx <= 2'd0;
                  if (r_remaining == 16'd1) r_state <= S_IDLE;
               end
            end
            S_DISCARD: if (w_byte_acc) begin
               r_remaining <= r_remaining - 16'd1;
               if (r_remaining == 16'd1) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase

`ifdef PARSER_TIMEOUT_EN
         // Abort only on a cycle with no accepted byte, so the FSM update
         // above is idle except for a possible drain.
         if ((r_state == S_IDLE) || w_byte_acc) begin
            r_idle_cnt <= 32'd0;
         end else if (r_idle_cnt == TIMEOUT_CYCLES - 32'd1) begin
            r_idle_cnt <= 32'd0;
            r_err      <= 1'b1;
            r_state    <= S_IDLE;
            r_byte_idx <= 2'd0;
            // A word still waiting is closed off as the packet's last.
            if (r_tvalid && !w_drain) r_tlast <= 1'b1;
         end else begin
            r_idle_cnt <= r_idle_cnt + 32'd1;
         end
`endif
      end
   end

   assign m_axis_tdata  = r_tdata;
   assign m_axis_tkeep  = r_tkeep;
   assign m_axis_tuser  = r_tuser;
   assign m_axis_tlast  = r_tlast;
   assign m_axis_tvalid = r_tvalid;
   assign err_o         = r_err;
   assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_uart_alu_pkt_parser.sv
module tb_uart_alu_pkt_parser;

   // ---------------- clock / reset ----------------
   logic        clk_i = 1'b0;
   logic        reset_i;
   logic [7:0]  s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic [31:0] m_axis_tdata;
   logic [3:0]  m_axis_tkeep;
   logic [7:0]  m_axis_tuser;
   logic        m_axis_tlast;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        err_o;
   logic [2:0]  dbg_state_o;

   always #5 clk_i = ~clk_i;

`ifdef PARSER_TIMEOUT_EN
   uart_alu_pkt_parser #(.TIMEOUT_CYCLES(32'd100)) dut (
`else
   uart_alu_pkt_parser dut (
`endif
      .clk_i(clk_i), .reset_i(reset_i),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
      .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .err_o(err_o), .dbg_state_o(dbg_state_o)
   );

   // ---------------- scoreboard ----------------
   // Expected word = {tdata, tkeep, tlast, tuser}
   logic [44:0] exp_q[$];
   logic [7:0]  tx_q[$];
   int checks = 0;
   int errors = 0;
   int err_cnt = 0;
   logic hold = 1'b0;
   logic rand_mode = 1'b0;

   function automatic logic [44:0] mk(input logic [31:0] d, input logic [3:0] k,
                                      input logic l, input logic [7:0] u);
      return {d, k, l, u};
   endfunction

   // Output monitor: drives m_axis_tready and pops the queue on each transfer.
   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(negedge clk_i);
         if (rand_mode) m_axis_tready = ($urandom_range(0, 3) != 0);
         else           m_axis_tready = !hold;
         #1;
         if (err_o) err_cnt++;
         if (m_axis_tvalid && m_axis_tready) begin
            logic [44:0] got;
            logic [44:0] exp;
            got = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL word_unexpected: got %h, need no word", got);
            end else begin
               exp = exp_q.pop_front();
               if (got !== exp) begin
                  errors++;
                  $display("FAIL word: got data=%h keep=%h last=%b user=%h, need data=%h keep=%h last=%b user=%h",
                           got[44:13], got[12:9], got[8], got[7:0],
                           exp[44:13], exp[12:9], exp[8], exp[7:0]);
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk_i);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = b;
      #1;
      while (!s_axis_tready && n < 300) begin
         @(negedge clk_i);
         #1;
         n++;
      end
      if (n >= 300) begin
         checks++;
         errors++;
         $display("FAIL byte_accept: tready stuck 0 for %0d cycles, need accept", n);
      end
      @(posedge clk_i);
      #1 s_axis_tvalid = 1'b0;
   endtask

   task automatic send_queue();
      while (tx_q.size() != 0) send_byte(tx_q.pop_front());
   endtask

   task automatic load_pkt(input logic [7:0] op, input logic [15:0] len,
                           input int npay, input logic [63:0] pay);
      tx_q.push_back(op);
      tx_q.push_back(8'h00);
      tx_q.push_back(len[7:0]);
      tx_q.push_back(len[15:8]);
      for (int i = 0; i < npay; i++) tx_q.push_back(pay[8*i +: 8]);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
         @(negedge clk_i);
         n++;
      end
      repeat (3) @(negedge clk_i);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d words left, need 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, need %h", name, act, exp);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0]  op;
      logic [15:0] len;
      int          npay;
      logic [63:0] pay;
      int          exp_err;
      int          nw;
      logic [44:0] w0;
      logic [44:0] w1;
   } vec_t;

   vec_t vecs[10];

   task automatic run_vec(input int i);
      int e0;
      e0 = err_cnt;
      if (vecs[i].nw > 0) exp_q.push_back(vecs[i].w0);
      if (vecs[i].nw > 1) exp_q.push_back(vecs[i].w1);
      load_pkt(vecs[i].op, vecs[i].len, vecs[i].npay, vecs[i].pay);
      send_queue();
      wait_drain($sformatf("vec%0d", i));
      check_val($sformatf("vec%0d_err", i), 64'(err_cnt - e0), 64'(vecs[i].exp_err));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int e0;
      vecs[0] = '{8'h01, 16'd12, 8, 64'h00000002_00000001, 0, 2,
                  mk(32'h00000001, 4'hF, 1'b0, 8'h01), mk(32'h00000002, 4'hF, 1'b1, 8'h01)};
      vecs[1] = '{8'hEC, 16'd10, 6, 64'h0000FFEE_DDCCBBAA, 0, 2,
                  mk(32'hDDCCBBAA, 4'hF, 1'b0, 8'hEC), mk(32'h0000FFEE, 4'h3, 1'b1, 8'hEC)};
      vecs[2] = '{8'h55, 16'd8, 4, 64'h00000000_44332211, 1, 0, 45'd0, 45'd0};
      vecs[3] = '{8'h01, 16'd8, 4, 64'h00000000_00000005, 0, 1,
                  mk(32'h00000005, 4'hF, 1'b1, 8'h01), 45'd0};
      vecs[4] = '{8'h01, 16'd7, 3, 64'h00000000_00090909, 1, 0, 45'd0, 45'd0};
      vecs[5] = '{8'h02, 16'd12, 8, 64'h00000004_00000003, 0, 2,
                  mk(32'h00000003, 4'hF, 1'b0, 8'h02), mk(32'h00000004, 4'hF, 1'b1, 8'h02)};
      vecs[6] = '{8'hEC, 16'd5, 1, 64'h00000000_0000007E, 0, 1,
                  mk(32'h0000007E, 4'h1, 1'b1, 8'hEC), 45'd0};
      vecs[7] = '{8'h01, 16'd4, 0, 64'd0, 1, 0, 45'd0, 45'd0};
      vecs[8] = '{8'hEC, 16'd7, 3, 64'h00000000_00030201, 0, 1,
                  mk(32'h00030201, 4'h7, 1'b1, 8'hEC), 45'd0};
      vecs[9] = '{8'h02, 16'd6, 2, 64'h00000000_0000AB12, 1, 0, 45'd0, 45'd0};

      reset_i = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = 8'h00;
      repeat (3) @(negedge clk_i);
      #2;
      check_val("reset_outputs",
                64'({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast, err_o}), 64'd0);
      check_val("reset_s_tready", 64'(s_axis_tready), 64'd1);
      check_val("reset_state", 64'(dbg_state_o), 64'd0);
      @(negedge clk_i);
      reset_i = 1'b0;

      for (int i = 0; i < 10; i++) run_vec(i);

      // Output backpressure: the byte that would complete word 2 must stall.
      hold = 1'b1;
      e0 = err_cnt;
      exp_q.push_back(mk(32'h0000AA03, 4'hF, 1'b0, 8'h02));
      exp_q.push_back(mk(32'h0000BB04, 4'hF, 1'b1, 8'h02));
      load_pkt(8'h02, 16'd12, 8, 64'h0000BB04_0000AA03);
      fork
         send_queue();
         begin
            repeat (50) @(negedge clk_i);
            #2;
            check_val("bp_s_tready", 64'(s_axis_tready), 64'd0);
            check_val("bp_m_tvalid", 64'(m_axis_tvalid), 64'd1);
            hold = 1'b0;
         end
      join
      wait_drain("bp");
      check_val("bp_err", 64'(err_cnt - e0), 64'd0);

      // Reset mid-packet: 6 bytes of an ADD len=12 then reset.
      e0 = err_cnt;
      load_pkt(8'h01, 16'd12, 2, 64'h0000_0000_0000_0077);
      send_queue();
      @(negedge clk_i);
      reset_i = 1'b1;
      @(posedge clk_i);
      #1;
      check_val("midrst_outputs",
                64'({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast, err_o}), 64'd0);
      check_val("midrst_s_tready", 64'(s_axis_tready), 64'd1);
      check_val("midrst_state", 64'(dbg_state_o), 64'd0);
      @(negedge clk_i);
      reset_i = 1'b0;
      run_vec(3);
      check_val("midrst_err", 64'(err_cnt - e0), 64'd0);

      // Random ECHO packets under random output backpressure.
      rand_mode = 1'b1;
      e0 = err_cnt;
      for (int p = 0; p < 6; p++) begin
         int          plen;
         logic [31:0] w;
         logic [3:0]  k;
         logic [7:0]  b;
         logic [15:0] len;
         plen = $urandom_range(1, 17);
         len  = 16'(plen + 4);
         tx_q.push_back(8'hEC);
         tx_q.push_back(8'(($urandom_range(0, 255))));
         tx_q.push_back(len[7:0]);
         tx_q.push_back(len[15:8]);
         w = 32'd0;
         k = 4'd0;
         for (int i = 0; i < plen; i++) begin
            b = 8'($urandom_range(0, 255));
            tx_q.push_back(b);
            w[8*(i%4) +: 8] = b;
            k[i%4] = 1'b1;
            if ((i % 4) == 3 || i == plen - 1) begin
               exp_q.push_back(mk(w, k, (i == plen - 1), 8'hEC));
               w = 32'd0;
               k = 4'd0;
            end
         end
         send_queue();
      end
      wait_drain("rand");
      check_val("rand_err", 64'(err_cnt - e0), 64'd0);
      rand_mode = 1'b0;
      @(negedge clk_i);

`ifdef PARSER_TIMEOUT_EN
      // Stall after the LEN_LO byte; the idle limit must abort the packet.
      e0 = err_cnt;
      tx_q.push_back(8'h01);
      tx_q.push_back(8'h00);
      tx_q.push_back(8'h08);
      send_queue();
      repeat (110) @(negedge clk_i);
      #2;
      check_val("timeout_err", 64'(err_cnt - e0), 64'd1);
      check_val("timeout_state", 64'(dbg_state_o), 64'd0);
      run_vec(3);
`endif

      check_val("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog so the bench always terminates.
   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached, need finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
